// File: rtl/pipeline_stage.sv
// Falling-edge valid/ready pipeline register with an optional skid entry.
// Define PIPE_SKID_EN for a 2-deep stage whose in_ready is decoded from registers only.
module pipeline_stage #(
   parameter int             N           = 32,
   parameter logic [N-1:0]   RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [N-1:0]     out_data,
   input  logic             out_ready,
   output logic [1:0]       count
);

`ifdef PIPE_SKID_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif

   logic [1:0]   count_q, count_d;
   logic [N-1:0] main_q, main_d;
   logic [N-1:0] skid_q, skid_d;
   logic         push, pop;

`ifdef PIPE_SKID_EN
   assign in_ready  = (count_q != DEPTH);
`else
   // Single entry: a slot frees up on the same edge the downstream pops.
   assign in_ready  = (count_q != DEPTH) || out_ready;
`endif

   assign out_valid = (count_q != 2'd0);
   assign out_data  = out_valid ? main_q : RESET_VALUE;
   assign count     = count_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      count_d = count_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         count_d = 2'd0;
         main_d  = RESET_VALUE;
         skid_d  = RESET_VALUE;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) main_d = in_data;
               else                 skid_d = in_data;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) begin
                  main_d = skid_q;
                  skid_d = RESET_VALUE;
               end
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               // Oldest leaves; the incoming word lands behind whatever remains.
               if (count_q == 2'd2) begin
                  main_d = skid_q;
                  skid_d = in_data;
               end else begin
                  main_d = in_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= 2'd0;
         main_q  <= RESET_VALUE;
         skid_q  <= RESET_VALUE;
      end else begin
         count_q <= count_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipeline_stage.sv
// Randomized self-checking bench for pipeline_stage against a queue model.
module tb_pipeline_stage;

   localparam logic [31:0] RV = 32'hDEAD_BEEF;
`ifdef PIPE_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [1:0]  count;

   int errors = 0;
   int checks = 0;

   logic [31:0] q[$];
   logic        m_rdy, m_push, m_pop;

   pipeline_stage #(.N(32), .RESET_VALUE(RV)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready();
      if (DEPTH == 2) return q.size() != 2;
      else            return (q.size() == 0) || out_ready;
   endfunction

   // Behavioural model: a bounded FIFO of pushed words.
   always @(negedge reset) q.delete();

   always @(negedge clk) begin
      if (reset) begin
         m_rdy  = model_ready();
         m_push = in_valid && m_rdy;
         m_pop  = (q.size() != 0) && out_ready;
         if (flush) q.delete();
         else begin
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(in_data);
         end
      end
   end

   always @(posedge clk) begin
      check("cmp_count", {62'd0, count}, 64'(q.size()));
      check("cmp_out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      check("cmp_out_data", {32'd0, out_data}, {32'd0, (q.size() != 0) ? q[0] : RV});
      check("cmp_in_ready", {63'd0, in_ready}, {63'd0, model_ready()});
   end

   task automatic drain();
      int n = 0;
      out_ready = 1'b1; in_valid = 1'b0; flush = 1'b0;
      while (count != 2'd0 && n < 10) begin
         @(posedge clk); #1; n++;
      end
      check("drain_empty", {62'd0, count}, 64'd0);
   endtask

   task automatic fill_full(input logic [31:0] base);
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1; in_data = base + 32'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("fill_count", {62'd0, count}, 64'(DEPTH));
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      check("rst_count", {62'd0, count}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", {32'd0, out_data}, {32'd0, RV});
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      #1 reset = 1'b1;
      in_valid = 1'b1; in_data = 32'hA5A5_0001;
      @(posedge clk);
      check("push1_count", {62'd0, count}, 64'd1);
      check("push1_valid", {63'd0, out_valid}, 64'd1);
      check("push1_data", {32'd0, out_data}, 64'h0000_0000_A5A5_0001);
      check("push1_model", 64'(q.size()), 64'd1);
      #1 drain();

      // Streaming one transfer per clock
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = 32'(i);
         @(posedge clk);
         check("stream_data", {32'd0, out_data}, 64'(i));
         check("stream_count", {62'd0, count}, 64'd1);
         #1;
      end
      drain();

      // Backpressure
      out_ready = 1'b0;
`ifdef PIPE_SKID_EN
      in_valid = 1'b1; in_data = 32'd1; @(posedge clk); #1;
      in_data = 32'd2; @(posedge clk);
      check("bp_count2", {62'd0, count}, 64'd2);
      check("bp_in_ready0", {63'd0, in_ready}, 64'd0);
      #1 in_data = 32'd3; @(posedge clk);
      check("bp_held_count", {62'd0, count}, 64'd2);
      check("bp_head1", {32'd0, out_data}, 64'd1);
      #1 out_ready = 1'b1; @(posedge clk);
      check("bp_head2", {32'd0, out_data}, 64'd2);
      #1 @(posedge clk);
      check("bp_head3", {32'd0, out_data}, 64'd3);
      check("bp_count_end", {62'd0, count}, 64'd1);
      #1 in_valid = 1'b0;
`else
      in_valid = 1'b1; in_data = 32'd1; @(posedge clk); #1;
      in_data = 32'd2; @(posedge clk);
      check("bp_in_ready0", {63'd0, in_ready}, 64'd0);
      check("bp_head1", {32'd0, out_data}, 64'd1);
      check("bp_count1", {62'd0, count}, 64'd1);
      #1 out_ready = 1'b1; #1;
      check("bp_in_ready1", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      check("bp_head2", {32'd0, out_data}, 64'd2);
      check("bp_count_end", {62'd0, count}, 64'd1);
      #1 in_valid = 1'b0;
`endif
      drain();

      // Flush beats simultaneous push and pop
      fill_full(32'h100);
      flush = 1'b1; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
      @(posedge clk);
      check("flush_count", {62'd0, count}, 64'd0);
      check("flush_valid", {63'd0, out_valid}, 64'd0);
      check("flush_data", {32'd0, out_data}, {32'd0, RV});
      #1 flush = 1'b0; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      check("flush_no_ghost", {63'd0, out_valid}, 64'd0);
      #1;

      // Asynchronous reset between edges
      fill_full(32'h200);
      reset = 1'b0; #1;
      check("arst_count", {62'd0, count}, 64'd0);
      check("arst_valid", {63'd0, out_valid}, 64'd0);
      check("arst_data", {32'd0, out_data}, {32'd0, RV});
      check("arst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1 reset = 1'b1;
      in_valid = 1'b1; in_data = 32'h300; out_ready = 1'b0;
      @(posedge clk);
      check("arst_first_edge", {32'd0, out_data}, 64'h300);
      #1 in_valid = 1'b0;

      // Randomized traffic, checked by the compare process
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_data   = $urandom;
         flush     = ($urandom_range(0, 15) == 0);
         reset     = ($urandom_range(0, 199) != 0);
         @(posedge clk); #1;
      end
      reset = 1'b1; flush = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
